cia_timer_bank: RTL and testbench
=================================

# cia_timer_bank

Parametrised interval-timer and interrupt block for the CIA family: `NCH` independent down-counters of `WIDTH` bits sharing one CIA-style interrupt control register. Each counter selects its tick source from phi2, CNT edges, or the previous channel's underflow, which gives cascades wider than 16 bits. It runs in the same phi2-strobed register-bus domain as the CIA cores and serves as the timer engine for future CIA variants and expansion chips.

## Interface
- `NCH`, 4: number of timer channels, 1..8.
- `WIDTH`, 16: counter width in bits, a multiple of 8, 8..32.
- `AW`, derived `$clog2(8*NCH+1)`: register address width.
- `clk` in 1: system clock.
- `res` in 1: reset, asynchronous and active-high.
- `phi2_p` in 1: one-clk strobe at the phi2 rising edge; every counting event happens on this strobe.
- `phi2_n` in 1: one-clk strobe at the phi2 falling edge; bus accesses are qualified by it.
- `cs_n` in 1: chip select, active low.
- `rw` in 1: 1 = read, 0 = write.
- `rs` in AW: register select.
- `db_in` in 8: write data.
- `db_out` out 8: read data, registered.
- `cnt_in` in NCH: per-channel CNT inputs.
- `tmr_out` out NCH: per-channel pulse/toggle outputs, registered on `phi2_p`.
- `irq_n` out 1: interrupt request, active low.

## Operation
- Register map for channel k, base 8k:
  - +0..+3: counter bytes, little-endian. A read returns the live counter. A write stores the latch byte. Byte indexes at or above WIDTH/8 read 0 and ignore writes.
  - +4: CR.
  - +5..+7: reserved, read 0.
- Global register at 8·NCH is the ICR:
  - Read returns {~irq_n, flags[6:0]}, with flags above NCH read as 0.
  - Write sets the mask: bit7=1 ORs bits[NCH-1:0] into the mask; bit7=0 clears them.
- CR bits:
  - [0] start.
  - [1] drive `tmr_out`.
  - [2] 1 = toggle mode, 0 = pulse mode.
  - [3] one-shot.
  - [4] force-load strobe, always reads 0.
  - [6:5] source: 00 phi2; 01 CNT rising edge; 10 underflow of channel k-1; 11 underflow of channel k-1 while `cnt_in[k]`=1.
  - Channel 0 treats sources 10 and 11 as 00.
- Tick: on `phi2_p`, if start=1 and the selected source is true, the counter decrements.
- Underflow: a tick while the counter is 0. On underflow:
  - Counter reloads from the latch.
  - flag[k] is set.
  - The toggle flip-flop inverts.
  - If one-shot=1, start clears.
  - The period is therefore latch+1 ticks.
- Writing the top latch byte (index WIDTH/8-1) while start=0 also loads the counter.
- Force load copies latch to counter on the next `phi2_p`, regardless of start. No tick occurs that cycle.
- Writing CR with start 0→1 sets the toggle flip-flop to 1.
- `tmr_out[k]` when CR[1]=0: 1.
- `tmr_out[k]` when CR[1]=1:
  - Pulse mode: 1 for the single phi2 cycle of an underflow, else 0.
  - Toggle mode: the toggle flip-flop.
- Cascade: source 10 on channel k sees channel k-1's underflow in the same `phi2_p`. It is combinational along the chain, no extra cycle.
- ICR read sets a pending-clear. The next `phi2_p` clears all flags and deasserts `irq_n`. A flag raised on that same `phi2_p` survives, because set wins over clear.
- `irq_n`:
  - Drops on the `phi2_p` after any (flag & mask) becomes nonzero.
  - Once low, stays low until cleared.

## Timing
- Reset values:
  - `db_out`=0, `irq_n`=1, `tmr_out`=all 1.
  - Counters 0, latches all-ones, CR=0, flags and mask 0, toggle flip-flops 0.
- Bus writes take effect on the `phi2_n` clk. Read data is valid one clk after `phi2_n`.
- CNT edge detect: `cnt_in` is sampled every clk. A rising edge is held until the next `phi2_p` and consumed there; at most one tick per phi2 cycle.
- Write to the counter-loading latch byte on the same cycle as an underflow reload: the written value wins.
- Reset mid-count returns to reset values immediately, asynchronously.

## Structure
- Package `cia_timer_pkg`:
  - CR bit-index constants.
  - Source-select enum.
  - Register offsets (CR=4, stride 8).
- Sub-module `cia_timer_chan`: one counter, its latch, CR and output logic. It takes `uf_in` from the previous channel and produces `uf_out`, `flag_set` and `tmr_out`.
- The top level generates `NCH` instances and holds the address decode, the ICR/mask and `irq_n`.

## Test plan
- Free-run from phi2: latch=3, CR=0x01.
  - Underflows every 4 `phi2_p`.
  - flag0 sets.
  - With mask 0x81, `irq_n` goes low one `phi2_p` later.
- One-shot toggle: latch=2, CR=0x0F.
  - `tmr_out[0]` is 1 at start, goes 0 at the single underflow and stays there.
  - CR[0] reads 0 afterwards.
- Cascade, WIDTH=16:
  - ch0 latch=0xFFFF, CR=0x01; ch1 latch=1, CR=0x41.
  - ch1 underflows once per 2×65536 phi2 cycles.
- CNT source: CR=0x21, latch=1, 5 CNT pulses.
  - Underflow on the 2nd and 4th pulses.
  - Two edges inside one phi2 cycle give one tick.
- ICR read races a new flag on the same `phi2_p`: the flag remains set and `irq_n` is reasserted.
- Asynchronous `res` pulse mid-count: all outputs and registers return to reset values without waiting for a clk edge.

Source files
------------

// File: rtl/cia_timer_pkg.sv
// cia_timer_pkg: CR bit indexes, tick-source encoding and register offsets shared by the timer bank
package cia_timer_pkg;
  localparam int CR_START   = 0;
  localparam int CR_OUTEN   = 1;
  localparam int CR_TOGGLE  = 2;
  localparam int CR_ONESHOT = 3;
  localparam int CR_LOAD    = 4;
  localparam int CR_SRC     = 5;
  localparam int REG_STRIDE = 8;
  localparam logic [2:0] REG_CR = 3'd4;
  typedef enum logic [1:0] {SRC_PHI2, SRC_CNT, SRC_UF, SRC_UF_CNT} src_e;
endpackage

// File: rtl/cia_timer_bank_if.sv
// cia_timer_bank_if: CPU register bus (cs_n, rw, rs, db_in from the master; db_out from the timer bank)
interface cia_timer_bank_if #(parameter int AW = 6);
  logic cs_n;
  logic rw;
  logic [AW-1:0] rs;
  logic [7:0] db_in;
  logic [7:0] db_out;
  modport master (output cs_n, rw, rs, db_in, input db_out);
  modport slave (input cs_n, rw, rs, db_in, output db_out);
endinterface

// File: rtl/cia_timer_chan.sv
// cia_timer_chan: one down-counter with latch, CR and tmr_out; ports: bus byte write/read, cnt_in, cascade uf_in/uf_out, tmr_out
module cia_timer_chan
  import cia_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       res,
  input  logic       phi2_p,
  input  logic       wr,
  input  logic [2:0] off,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  input  logic       cnt_in,
  input  logic       uf_in,
  output logic       uf_out,
  output logic       tmr_out
);
  localparam int NB = WIDTH / 8;
  logic [WIDTH-1:0] cnt_q, cnt_d, latch_q, latch_d;
  logic [7:0] cr_q, cr_d;
  logic fl_q, fl_d, tog_q, tog_d, tmr_q, tmr_d, edge_q, edge_d, cnt_in_q;
  logic rise, src_ok, tick, uf;
  src_e src;
  always_comb begin
    // channel 0 has no predecessor, so the cascade sources fall back to phi2
    src = (FIRST && cr_q[CR_SRC+1]) ? SRC_PHI2 : src_e'(cr_q[CR_SRC+:2]);
    rise = cnt_in & ~cnt_in_q;
    src_ok = src == SRC_PHI2 ? 1'b1 : src == SRC_CNT ? (edge_q | rise) : src == SRC_UF ? uf_in : (uf_in & cnt_in);
    // a pending force load owns this phi2_p: no tick, no underflow
    tick = phi2_p & cr_q[CR_START] & src_ok & ~fl_q;
    uf = tick && cnt_q == '0;
    latch_d = latch_q;
    for (int i = 0; i < NB; i++) if (wr && off == 3'(i)) latch_d[8*i+:8] = wr_data;
    // reloads take latch_d so a latch write coinciding with a reload wins
    cnt_d = (phi2_p && fl_q) || uf ? latch_d : tick ? cnt_q - WIDTH'(1) : cnt_q;
    if (wr && off == 3'(NB - 1) && !cr_q[CR_START]) cnt_d = latch_d;
    cr_d = cr_q;
    if (uf && cr_q[CR_ONESHOT]) cr_d[CR_START] = 1'b0;
    fl_d = fl_q & ~phi2_p;
    tog_d = uf ? ~tog_q : tog_q;
    if (wr && off == REG_CR) begin
      cr_d = wr_data;
      cr_d[CR_LOAD] = 1'b0;
      fl_d = fl_d | wr_data[CR_LOAD];
      if (wr_data[CR_START] && !cr_q[CR_START]) tog_d = 1'b1;
    end
    tmr_d = phi2_p ? (!cr_q[CR_OUTEN] ? 1'b1 : cr_q[CR_TOGGLE] ? tog_d : uf) : tmr_q;
    // a CNT edge is remembered until the next phi2_p, which consumes it
    edge_d = phi2_p ? 1'b0 : edge_q | rise;
    rd_data = '0;
    for (int i = 0; i < NB; i++) if (off == 3'(i)) rd_data = cnt_q[8*i+:8];
    if (off == REG_CR) rd_data = cr_q;
  end
  always_ff @(posedge clk or posedge res)
    if (res) begin
      cnt_q <= '0;
      latch_q <= '1;
      cr_q <= '0;
      fl_q <= 1'b0;
      tog_q <= 1'b0;
      tmr_q <= 1'b1;
      edge_q <= 1'b0;
      cnt_in_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      latch_q <= latch_d;
      cr_q <= cr_d;
      fl_q <= fl_d;
      tog_q <= tog_d;
      tmr_q <= tmr_d;
      edge_q <= edge_d;
      cnt_in_q <= cnt_in;
    end
  assign uf_out = uf;
  assign tmr_out = tmr_q;
endmodule

// File: rtl/cia_timer_bank.sv
// cia_timer_bank: NCH cascadable timers with a shared ICR; ports: clk, res, phi2_p/phi2_n strobes, bus (slave), cnt_in, tmr_out, irq_n
module cia_timer_bank
  import cia_timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             phi2_p,
  input  logic             phi2_n,
  cia_timer_bank_if.slave  bus,
  input  logic [NCH-1:0]   cnt_in,
  output logic [NCH-1:0]   tmr_out,
  output logic             irq_n
);
  localparam int AW = $clog2(8 * NCH + 1);
  localparam int CW = AW - 3;
  logic [CW-1:0] ch;
  logic [2:0] off;
  logic acc, icr_sel;
  logic [NCH-1:0] wr;
  logic [NCH:0] uf;
  logic [7:0] rd_ch [NCH];
  logic [NCH-1:0] flags_q, flags_d, mask_q, mask_d;
  logic irq_n_q, irq_n_d, clr_q, clr_d;
  logic [7:0] db_q, db_d, rdata;
  logic [6:0] fl7;
  assign uf[0] = 1'b0;
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    cia_timer_chan #(.WIDTH(WIDTH), .FIRST(1'(k == 0))) u_ch (
      .clk(clk), .res(res), .phi2_p(phi2_p), .wr(wr[k]), .off(off), .wr_data(bus.db_in),
      .rd_data(rd_ch[k]), .cnt_in(cnt_in[k]), .uf_in(uf[k]), .uf_out(uf[k+1]), .tmr_out(tmr_out[k]));
  end
  always_comb begin
    ch = bus.rs[AW-1:3];
    off = bus.rs[2:0];
    acc = phi2_n & ~bus.cs_n;
    icr_sel = bus.rs == AW'(REG_STRIDE * NCH);
    wr = '0;
    for (int i = 0; i < NCH; i++) wr[i] = acc && !bus.rw && ch == CW'(i);
    fl7 = '0;
    for (int i = 0; i < (NCH < 7 ? NCH : 7); i++) fl7[i] = flags_q[i];
    rdata = icr_sel ? {~irq_n_q, fl7} : '0;
    for (int i = 0; i < NCH; i++) if (ch == CW'(i)) rdata = rd_ch[i];
    db_d = acc && bus.rw ? rdata : db_q;
    clr_d = acc && bus.rw && icr_sel ? 1'b1 : phi2_p ? 1'b0 : clr_q;
    // new underflows are ORed in after the clear so set wins over clear
    flags_d = (phi2_p && clr_q ? '0 : flags_q) | uf[NCH:1];
    irq_n_d = !phi2_p ? irq_n_q : clr_q ? 1'b1 : |(flags_q & mask_q) ? 1'b0 : irq_n_q;
    mask_d = !(acc && !bus.rw && icr_sel) ? mask_q :
             bus.db_in[7] ? mask_q | bus.db_in[NCH-1:0] : mask_q & ~bus.db_in[NCH-1:0];
  end
  always_ff @(posedge clk or posedge res)
    if (res) begin
      flags_q <= '0;
      mask_q <= '0;
      irq_n_q <= 1'b1;
      clr_q <= 1'b0;
      db_q <= '0;
    end else begin
      flags_q <= flags_d;
      mask_q <= mask_d;
      irq_n_q <= irq_n_d;
      clr_q <= clr_d;
      db_q <= db_d;
    end
  assign bus.db_out = db_q;
  assign irq_n = irq_n_q;
endmodule

// File: tb/tb_cia_timer_bank.sv
// tb_cia_timer_bank: directed stimulus with immediate-assertion checks for cia_timer_bank (NCH=4, WIDTH=16)
module tb_cia_timer_bank;
  logic clk = 1'b0;
  logic res = 1'b1;
  logic phi2_p = 1'b0;
  logic phi2_n = 1'b0;
  logic [3:0] cnt_in = '0;
  logic [3:0] tmr_out;
  logic irq_n;
  int checks = 0;
  int errors = 0;
  cia_timer_bank_if #(.AW(6)) bus ();
  cia_timer_bank #(.NCH(4), .WIDTH(16)) dut (
    .clk(clk), .res(res), .phi2_p(phi2_p), .phi2_n(phi2_n), .bus(bus),
    .cnt_in(cnt_in), .tmr_out(tmr_out), .irq_n(irq_n));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pp();
    phi2_p = 1'b1;
    cyc();
    phi2_p = 1'b0;
    cyc();
  endtask
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus.cs_n = 1'b0; bus.rw = 1'b0; bus.rs = a; bus.db_in = d; phi2_n = 1'b1;
    cyc();
    bus.cs_n = 1'b1; bus.rw = 1'b1; phi2_n = 1'b0;
    cyc();
  endtask
  task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string tag);
    bus.cs_n = 1'b0; bus.rw = 1'b1; bus.rs = a; phi2_n = 1'b1;
    cyc();
    bus.cs_n = 1'b1; phi2_n = 1'b0;
    chk(32'(bus.db_out), 32'(exp), tag);
    cyc();
  endtask
  task automatic pulse();
    cnt_in[0] = 1'b1;
    cyc();
    cnt_in[0] = 1'b0;
    cyc();
  endtask
  initial begin
    bus.cs_n = 1'b1; bus.rw = 1'b1; bus.rs = '0; bus.db_in = '0;
    cyc();
    cyc();
    chk(32'(bus.db_out), 32'h00, "rst_db_out");
    chk(32'(irq_n), 32'h1, "rst_irq_n");
    chk(32'(tmr_out), 32'hF, "rst_tmr_out");
    res = 1'b0;
    cyc();
    // force load exposes the all-ones reset latch; byte 2 is beyond WIDTH
    wr(6'd4, 8'h10);
    pp();
    rd(6'd0, 8'hFF, "fload_lo");
    rd(6'd1, 8'hFF, "fload_hi");
    rd(6'd2, 8'h00, "byte_oob");
    rd(6'd4, 8'h00, "cr_load_reads0");
    // free run from phi2, latch 3
    wr(6'd0, 8'h03);
    wr(6'd1, 8'h00);
    rd(6'd0, 8'h03, "toplatch_loads");
    wr(6'd32, 8'h81);
    wr(6'd4, 8'h01);
    pp(); pp(); pp();
    rd(6'd0, 8'h00, "ch0_at_zero");
    pp();
    rd(6'd0, 8'h03, "ch0_reload");
    chk(32'(irq_n), 32'h1, "irq_not_yet");
    pp();
    chk(32'(irq_n), 32'h0, "irq_low");
    rd(6'd32, 8'h81, "icr_flag0");
    pp();
    chk(32'(irq_n), 32'h1, "irq_cleared");
    pp();
    rd(6'd32, 8'h00, "icr_empty");
    pp();
    chk(32'(irq_n), 32'h1, "race_irq_hi");
    pp();
    chk(32'(irq_n), 32'h0, "race_irq_low");
    rd(6'd32, 8'h81, "race_flag_kept");
    wr(6'd4, 8'h00);
    wr(6'd32, 8'h01);
    pp();
    chk(32'(irq_n), 32'h1, "mask_cleared");
    chk(32'(tmr_out), 32'hF, "tmr_out_disabled");
    // one-shot toggle on ch1, latch 2
    wr(6'd8, 8'h02);
    wr(6'd9, 8'h00);
    wr(6'd12, 8'h0F);
    pp();
    chk(32'(tmr_out[1]), 32'h1, "tog_start");
    pp();
    chk(32'(tmr_out[1]), 32'h1, "tog_before_uf");
    pp();
    chk(32'(tmr_out[1]), 32'h0, "tog_at_uf");
    pp();
    chk(32'(tmr_out[1]), 32'h0, "tog_stays");
    rd(6'd8, 8'h02, "oneshot_reload");
    rd(6'd12, 8'h0E, "oneshot_start_clr");
    chk(32'(irq_n), 32'h1, "unmasked_no_irq");
    // pulse mode with ch3 cascaded from ch2, both latch 1
    wr(6'd16, 8'h01);
    wr(6'd17, 8'h00);
    wr(6'd24, 8'h01);
    wr(6'd25, 8'h00);
    wr(6'd28, 8'h43);
    wr(6'd20, 8'h03);
    pp();
    chk(32'(tmr_out), 32'b0001, "casc_p1");
    pp();
    chk(32'(tmr_out), 32'b0101, "casc_p2");
    pp();
    chk(32'(tmr_out), 32'b0001, "casc_p3");
    pp();
    chk(32'(tmr_out), 32'b1101, "casc_p4");
    rd(6'd24, 8'h01, "casc_ch3_reload");
    rd(6'd32, 8'h0E, "casc_flags");
    wr(6'd20, 8'h00);
    wr(6'd28, 8'h00);
    pp();
    // CNT edges on ch0, latch 1, pulse output
    wr(6'd0, 8'h01);
    wr(6'd1, 8'h00);
    wr(6'd4, 8'h23);
    pp();
    rd(6'd0, 8'h01, "cnt_no_edge");
    pulse(); pp();
    chk(32'(tmr_out[0]), 32'h0, "cnt_p1");
    pulse(); pp();
    chk(32'(tmr_out[0]), 32'h1, "cnt_p2_uf");
    pulse(); pp();
    chk(32'(tmr_out[0]), 32'h0, "cnt_p3");
    pulse(); pp();
    chk(32'(tmr_out[0]), 32'h1, "cnt_p4_uf");
    pulse(); pulse(); pp();
    rd(6'd0, 8'h00, "cnt_double_one_tick");
    chk(32'(tmr_out[0]), 32'h0, "cnt_double_no_uf");
    pulse(); pp();
    chk(32'(tmr_out[0]), 32'h1, "cnt_next_uf");
    wr(6'd4, 8'h00);
    // async reset in the middle of a count
    wr(6'd32, 8'h82);
    wr(6'd12, 8'h03);
    pp(); pp(); pp(); pp();
    chk(32'(irq_n), 32'h0, "pre_rst_irq");
    chk(32'(tmr_out), 32'b1101, "pre_rst_tmr");
    rd(6'd8, 8'h01, "pre_rst_cnt");
    #2 res = 1'b1;
    #1;
    chk(32'(irq_n), 32'h1, "async_irq_n");
    chk(32'(tmr_out), 32'hF, "async_tmr_out");
    chk(32'(bus.db_out), 32'h00, "async_db_out");
    #1 res = 1'b0;
    cyc();
    rd(6'd8, 8'h00, "post_rst_cnt");
    rd(6'd12, 8'h00, "post_rst_cr");
    rd(6'd32, 8'h00, "post_rst_icr");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
